// File: rtl/mips_mem_pkg.sv
// Shared definitions for the cached MEM stage of the MIPS core.
//   - Default widths for the stage parameters.
//   - FSM state encoding for the miss / write-through sequencer.
//   - Helper that derives the tag width from address and index widths.
package mips_mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int DEST_W_DEF = 3;
    localparam int IDX_W_DEF  = 6;
    localparam int CNT_W_DEF  = 16;

    // Tag covers every address bit above the line index.
    function automatic int tag_w(input int addr_w, input int idx_w);
        return addr_w - idx_w;
    endfunction

    localparam int TAG_W_DEF = tag_w(ADDR_W_DEF, IDX_W_DEF);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ_MISS  = 2'd1,
        ST_WRITE_THRU = 2'd2,
        ST_COMPLETE   = 2'd3
    } mem_state_e;

endpackage

// File: rtl/cache_line_array.sv
// Direct-mapped line storage: one word per line.
//   clk, rst       : clock, asynchronous active-low reset (clears valid bits only)
//   rd_idx         : combinational read index
//   rd_valid/tag/data : line contents at rd_idx
//   wr_en          : synchronous write of tag/data and set of valid at wr_idx
//   wr_idx/tag/data: write port
module cache_line_array
    import mips_mem_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int LINES = 2 ** IDX_W;

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    always_comb begin
        // NOTE: assign a default before any conditional update so no latch is inferred.
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops sample together.
            valid_q <= valid_d;
        end
    end

    // NOTE: tag/data storage has no reset; valid bits alone make stale contents invisible,
    // and leaving it unreset lets it map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/mem_stage_cached.sv
// MEM pipeline stage with a direct-mapped, write-through, no-write-allocate cache.
//   clk, rst          : clock, asynchronous active-low reset
//   in_*              : instruction from EX (held stable by upstream while memory_stall=1)
//   wb_*              : registered instruction to WB (all-zero bubble while stalled)
//   fwd_dest, fwd_res : forwarding to the hazard unit
//   memory_stall      : freezes upstream stages
//   mem_*             : off-chip req/ready interface (request side registered)
//   hit_cnt, miss_cnt : saturating statistics
module mem_stage_cached
    import mips_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEST_W = DEST_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_wb_en,
    input  logic [DEST_W-1:0] in_wb_dest,
    input  logic              in_wb_sel,
    output logic [ADDR_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic              wb_en,
    output logic [DEST_W-1:0] wb_dest,
    output logic              wb_sel,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_res,
    output logic              memory_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int TAG_W = ADDR_W - IDX_W;

    mem_state_e state_q, state_d;

    logic [ADDR_W-1:0] wb_alu_result_q, wb_alu_result_d;
    logic [DATA_W-1:0] wb_mem_data_q,   wb_mem_data_d;
    logic              wb_en_q,         wb_en_d;
    logic [DEST_W-1:0] wb_dest_q,       wb_dest_d;
    logic              wb_sel_q,        wb_sel_d;
    logic              mem_req_q,       mem_req_d;
    logic              mem_we_q,        mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,      mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,     mem_wdata_d;
    logic [DATA_W-1:0] fill_buf_q,      fill_buf_d;
    logic              wr_hit_q,        wr_hit_d;
    logic [CNT_W-1:0]  hit_cnt_q,       hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q,      miss_cnt_d;

    logic [IDX_W-1:0]  lookup_idx;
    logic [TAG_W-1:0]  lookup_tag;
    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic [DATA_W-1:0] line_data;
    logic              hit_c;

    logic              arr_wr_en;
    logic [DATA_W-1:0] arr_wr_data;
    logic              stall_c;
    logic              hit_inc;
    logic              miss_inc;
    logic [DATA_W-1:0] load_data;

    // ---------------- cache lookup ----------------
    assign lookup_idx = in_alu_result[IDX_W-1:0];
    assign lookup_tag = in_alu_result[ADDR_W-1:IDX_W];
    assign hit_c      = line_valid && (line_tag == lookup_tag);

    // Fills and write-through updates use the held request address.
    cache_line_array #(
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_lines (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (lookup_idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (arr_wr_en),
        .wr_idx   (mem_addr_q[IDX_W-1:0]),
        .wr_tag   (mem_addr_q[ADDR_W-1:IDX_W]),
        .wr_data  (arr_wr_data)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_mem_write) begin
                    state_d = ST_WRITE_THRU;
                end else if (in_mem_read && !hit_c) begin
                    state_d = ST_READ_MISS;
                end
            end
            ST_READ_MISS, ST_WRITE_THRU: begin
                if (mem_ready) begin
                    state_d = ST_COMPLETE;
                end
            end
            ST_COMPLETE: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs and datapath ----------------
    always_comb begin
        stall_c     = 1'b0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        arr_wr_en   = 1'b0;
        arr_wr_data = mem_rdata;
        load_data   = '0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_buf_d  = fill_buf_q;
        wr_hit_d    = wr_hit_q;

        case (state_q)
            ST_IDLE: begin
                if (in_mem_write) begin
                    // Write-through always goes off-chip; the hit only decides
                    // whether the cached copy is refreshed afterwards.
                    stall_c     = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = in_alu_result;
                    mem_wdata_d = in_store_data;
                    wr_hit_d    = hit_c;
                    hit_inc     = hit_c;
                    miss_inc    = !hit_c;
                end else if (in_mem_read) begin
                    if (hit_c) begin
                        hit_inc   = 1'b1;
                        load_data = line_data;
                    end else begin
                        stall_c    = 1'b1;
                        miss_inc   = 1'b1;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = in_alu_result;
                    end
                end
            end
            ST_READ_MISS: begin
                stall_c = 1'b1;
                if (mem_ready) begin
                    mem_req_d   = 1'b0;
                    arr_wr_en   = 1'b1;
                    arr_wr_data = mem_rdata;
                    fill_buf_d  = mem_rdata;
                end
            end
            ST_WRITE_THRU: begin
                stall_c = 1'b1;
                if (mem_ready) begin
                    mem_req_d   = 1'b0;
                    arr_wr_en   = wr_hit_q;
                    arr_wr_data = mem_wdata_q;
                end
            end
            ST_COMPLETE: begin
                if (in_mem_read && !in_mem_write) begin
                    load_data = fill_buf_q;
                end
            end
            default: ;
        endcase

        // Bubble to WB while the stage is frozen.
        if (stall_c) begin
            wb_alu_result_d = '0;
            wb_mem_data_d   = '0;
            wb_en_d         = 1'b0;
            wb_dest_d       = '0;
            wb_sel_d        = 1'b0;
        end else begin
            wb_alu_result_d = in_alu_result;
            wb_mem_data_d   = load_data;
            wb_en_d         = in_wb_en;
            wb_dest_d       = in_wb_dest;
            wb_sel_d        = in_wb_sel;
        end

        hit_cnt_d  = (hit_inc  && (hit_cnt_q  != '1)) ? hit_cnt_q  + CNT_W'(1) : hit_cnt_q;
        miss_cnt_d = (miss_inc && (miss_cnt_q != '1)) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_alu_result_q <= '0;
            wb_mem_data_q   <= '0;
            wb_en_q         <= 1'b0;
            wb_dest_q       <= '0;
            wb_sel_q        <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            fill_buf_q      <= '0;
            wr_hit_q        <= 1'b0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
        end else begin
            wb_alu_result_q <= wb_alu_result_d;
            wb_mem_data_q   <= wb_mem_data_d;
            wb_en_q         <= wb_en_d;
            wb_dest_q       <= wb_dest_d;
            wb_sel_q        <= wb_sel_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            fill_buf_q      <= fill_buf_d;
            wr_hit_q        <= wr_hit_d;
            hit_cnt_q       <= hit_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
        end
    end

    // ---------------- outputs ----------------
    // Combinational outputs are forced low during reset so every port reads 0.
    always_comb begin
        fwd_res = '0;
        if (!in_wb_sel) begin
            fwd_res = DATA_W'(in_alu_result);
        end else if (state_q == ST_COMPLETE) begin
            fwd_res = fill_buf_q;
        end else begin
            fwd_res = line_data;
        end
        if (!rst) begin
            fwd_res = '0;
        end
    end

    assign fwd_dest      = rst ? in_wb_dest : '0;
    assign memory_stall  = stall_c && rst;

    assign wb_alu_result = wb_alu_result_q;
    assign wb_mem_data   = wb_mem_data_q;
    assign wb_en         = wb_en_q;
    assign wb_dest       = wb_dest_q;
    assign wb_sel        = wb_sel_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_mem_stage_cached.sv
// Self-checking bench for mem_stage_cached. The reference keeps a per-index
// record of which full address is cached, an associative off-chip memory and
// saturating counters, and derives every expectation from those.
module tb_mem_stage_cached;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEST_W = 3;
    localparam int IDX_W  = 6;
    localparam int CNT_W  = 10;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] in_alu_result = '0;
    logic [DATA_W-1:0] in_store_data = '0;
    logic              in_mem_read = 1'b0;
    logic              in_mem_write = 1'b0;
    logic              in_wb_en = 1'b0;
    logic [DEST_W-1:0] in_wb_dest = '0;
    logic              in_wb_sel = 1'b0;
    logic [ADDR_W-1:0] wb_alu_result;
    logic [DATA_W-1:0] wb_mem_data;
    logic              wb_en;
    logic [DEST_W-1:0] wb_dest;
    logic              wb_sel;
    logic [DEST_W-1:0] fwd_dest;
    logic [DATA_W-1:0] fwd_res;
    logic              memory_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    int checks = 0;
    int failures = 0;

    // Reference state
    logic [DATA_W-1:0] ext_mem    [logic [ADDR_W-1:0]];
    logic [ADDR_W-1:0] cache_addr [int];
    logic [DATA_W-1:0] cache_data [int];
    int exp_hit = 0;
    int exp_miss = 0;

    mem_stage_cached #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .DEST_W (DEST_W),
        .IDX_W  (IDX_W),  .CNT_W  (CNT_W)
    ) dut (
        .clk (clk), .rst (rst),
        .in_alu_result (in_alu_result), .in_store_data (in_store_data),
        .in_mem_read (in_mem_read), .in_mem_write (in_mem_write),
        .in_wb_en (in_wb_en), .in_wb_dest (in_wb_dest), .in_wb_sel (in_wb_sel),
        .wb_alu_result (wb_alu_result), .wb_mem_data (wb_mem_data),
        .wb_en (wb_en), .wb_dest (wb_dest), .wb_sel (wb_sel),
        .fwd_dest (fwd_dest), .fwd_res (fwd_res), .memory_stall (memory_stall),
        .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr),
        .mem_wdata (mem_wdata), .mem_rdata (mem_rdata), .mem_ready (mem_ready),
        .hit_cnt (hit_cnt), .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] ext_read(input logic [ADDR_W-1:0] a);
        if (ext_mem.exists(a)) return ext_mem[a];
        return (a * 16'h003B) ^ 16'hC5A7;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic logic model_hit(input logic [ADDR_W-1:0] a);
        int idx;
        idx = int'(a) % (1 << IDX_W);
        return cache_addr.exists(idx) && (cache_addr[idx] == a);
    endfunction

    task automatic check_counters(input string name);
        checks++;
        if (hit_cnt !== CNT_W'(exp_hit) || miss_cnt !== CNT_W'(exp_miss)) begin
            failures++;
            $display("FAIL %s counters: hit=%0d miss=%0d, expected hit=%0d miss=%0d",
                     name, hit_cnt, miss_cnt, exp_hit, exp_miss);
        end
    endtask

    // Executes one instruction from IDLE, starting just after a rising edge,
    // and ends just after the edge that hands it to WB. lat = mem_req cycles.
    task automatic do_op(input string name, input logic rd, input logic wr,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] sdata,
                         input logic wen, input logic [DEST_W-1:0] dest,
                         input logic sel, input int lat);
        int idx;
        logic hit, stall_exp, is_load;
        logic [DATA_W-1:0] exp_data;
        idx = int'(addr) % (1 << IDX_W);
        hit = model_hit(addr);
        is_load = rd && !wr;
        stall_exp = wr || (rd && !hit);
        exp_data = '0;
        in_alu_result = addr; in_store_data = sdata;
        in_mem_read = rd; in_mem_write = wr;
        in_wb_en = wen; in_wb_dest = dest; in_wb_sel = sel;

        @(negedge clk);
        checks++;
        if (memory_stall !== stall_exp || fwd_dest !== dest) begin
            failures++;
            $display("FAIL %s stall/fwd_dest: stall=%b dest=%0d, expected stall=%b dest=%0d",
                     name, memory_stall, fwd_dest, stall_exp, dest);
        end

        if (!stall_exp) begin
            if (is_load) exp_data = cache_data[idx];
            if (!sel || is_load) begin
                checks++;
                if (fwd_res !== (sel ? exp_data : addr)) begin
                    failures++;
                    $display("FAIL %s fwd_res: got %h expected %h", name, fwd_res,
                             sel ? exp_data : addr);
                end
            end
            if (rd) exp_hit = sat_inc(exp_hit);
        end else begin
            if (wr && hit) exp_hit = sat_inc(exp_hit);
            else           exp_miss = sat_inc(exp_miss);
            exp_data = wr ? sdata : ext_read(addr);

            @(posedge clk); #1;
            checks++;
            if (mem_req !== 1'b1 || mem_we !== wr || mem_addr !== addr ||
                (wr && mem_wdata !== sdata)) begin
                failures++;
                $display("FAIL %s request: req=%b we=%b addr=%h wdata=%h, expected req=1 we=%b addr=%h wdata=%h",
                         name, mem_req, mem_we, mem_addr, mem_wdata, wr, addr, sdata);
            end
            checks++;
            if ({wb_en, wb_dest, wb_sel, wb_alu_result, wb_mem_data} !== '0) begin
                failures++;
                $display("FAIL %s bubble: wb_en=%b dest=%0d sel=%b alu=%h data=%h, expected all zero",
                         name, wb_en, wb_dest, wb_sel, wb_alu_result, wb_mem_data);
            end
            check_counters(name);

            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                checks++;
                if (mem_req !== 1'b1 || memory_stall !== 1'b1 || mem_addr !== addr) begin
                    failures++;
                    $display("FAIL %s wait cycle %0d: req=%b stall=%b addr=%h, expected 1 1 %h",
                             name, k, mem_req, memory_stall, mem_addr, addr);
                end
                mem_rdata = (k == lat) ? ext_read(addr) : DATA_W'($urandom);
                mem_ready = (k == lat);
                @(posedge clk); #1;
                mem_ready = 1'b0;
                mem_rdata = DATA_W'($urandom);
            end
            checks++;
            if (mem_req !== 1'b0) begin
                failures++;
                $display("FAIL %s req drop: mem_req=%b expected 0", name, mem_req);
            end

            if (wr) begin
                ext_mem[addr] = sdata;
                if (hit) cache_data[idx] = sdata;
            end else begin
                cache_addr[idx] = addr;
                cache_data[idx] = exp_data;
            end

            @(negedge clk);
            checks++;
            if (memory_stall !== 1'b0) begin
                failures++;
                $display("FAIL %s complete stall: got %b expected 0", name, memory_stall);
            end
            if (!sel || is_load) begin
                checks++;
                if (fwd_res !== (sel ? exp_data : addr)) begin
                    failures++;
                    $display("FAIL %s complete fwd_res: got %h expected %h", name, fwd_res,
                             sel ? exp_data : addr);
                end
            end
        end

        @(posedge clk); #1;
        checks++;
        if (wb_en !== wen || wb_dest !== dest || wb_sel !== sel || wb_alu_result !== addr ||
            (is_load && wb_mem_data !== exp_data)) begin
            failures++;
            $display("FAIL %s wb: en=%b dest=%0d sel=%b alu=%h data=%h, expected en=%b dest=%0d sel=%b alu=%h data=%h",
                     name, wb_en, wb_dest, wb_sel, wb_alu_result, wb_mem_data,
                     wen, dest, sel, addr, exp_data);
        end
        check_counters(name);
    endtask

    task automatic idle_inputs();
        in_mem_read = 1'b0; in_mem_write = 1'b0; in_wb_en = 1'b0;
        in_wb_sel = 1'b0; in_wb_dest = '0; in_alu_result = '0; in_store_data = '0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #11;
        checks++;
        if ({wb_alu_result, wb_mem_data, wb_en, wb_dest, wb_sel, fwd_dest, fwd_res,
             memory_stall, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt} !== '0) begin
            failures++;
            $display("FAIL reset outputs: some output nonzero (stall=%b req=%b hit=%0d miss=%0d wb_en=%b)",
                     memory_stall, mem_req, hit_cnt, miss_cnt, wb_en);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_miss_fill();
        ext_mem[16'h0040] = 16'hBEEF;
        do_op("read_miss_0040", 1, 0, 16'h0040, 16'h0, 1, 3'd5, 1, 3);
        checks++;
        if (wb_mem_data !== 16'hBEEF || miss_cnt !== CNT_W'(1)) begin
            failures++;
            $display("FAIL read_miss_value: data=%h miss=%0d, expected BEEF 1", wb_mem_data, miss_cnt);
        end
    endtask

    task automatic test_read_hit();
        do_op("read_hit_0040", 1, 0, 16'h0040, 16'h0, 1, 3'd2, 1, 0);
        checks++;
        if (wb_mem_data !== 16'hBEEF || hit_cnt !== CNT_W'(1) || miss_cnt !== CNT_W'(1)) begin
            failures++;
            $display("FAIL read_hit_value: data=%h hit=%0d miss=%0d, expected BEEF 1 1",
                     wb_mem_data, hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_write_through();
        do_op("store_hit_0040", 0, 1, 16'h0040, 16'h1234, 0, 3'd0, 0, 2);
        do_op("read_after_store", 1, 0, 16'h0040, 16'h0, 1, 3'd3, 1, 0);
        do_op("store_miss_0080", 0, 1, 16'h0080, 16'h5555, 0, 3'd0, 0, 1);
        do_op("read_no_allocate", 1, 0, 16'h0040, 16'h0, 1, 3'd4, 1, 0);
        checks++;
        if (wb_mem_data !== 16'h1234) begin
            failures++;
            $display("FAIL no_allocate: data=%h expected 1234", wb_mem_data);
        end
    endtask

    task automatic test_conflict();
        do_op("evict_2040", 1, 0, 16'h2040, 16'h0, 1, 3'd1, 1, 1);
        do_op("conflict_0040", 1, 0, 16'h0040, 16'h0, 1, 3'd1, 1, 2);
        do_op("conflict_1040", 1, 0, 16'h1040, 16'h0, 1, 3'd1, 1, 1);
        do_op("conflict_0040b", 1, 0, 16'h0040, 16'h0, 1, 3'd1, 1, 4);
    endtask

    task automatic test_reset_in_flight();
        in_alu_result = 16'h0301; in_mem_read = 1'b1; in_mem_write = 1'b0;
        in_wb_en = 1'b1; in_wb_dest = 3'd6; in_wb_sel = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL inflight_req: mem_req=%b expected 1", mem_req);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || memory_stall !== 1'b0 || hit_cnt !== '0 ||
            miss_cnt !== '0 || wb_en !== 1'b0) begin
            failures++;
            $display("FAIL inflight_reset: req=%b stall=%b hit=%0d miss=%0d wb_en=%b, expected all 0",
                     mem_req, memory_stall, hit_cnt, miss_cnt, wb_en);
        end
        idle_inputs();
        cache_addr.delete();
        cache_data.delete();
        exp_hit = 0;
        exp_miss = 0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        do_op("reread_0040_after_reset", 1, 0, 16'h0040, 16'h0, 1, 3'd1, 1, 1);
        do_op("reread_0301_after_reset", 1, 0, 16'h0301, 16'h0, 1, 3'd6, 1, 2);
    endtask

    task automatic test_ready_in_idle();
        idle_inputs();
        mem_ready = 1'b1;
        mem_rdata = 16'hDEAD;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (memory_stall !== 1'b0) begin
                failures++;
                $display("FAIL ready_idle_stall: got %b expected 0", memory_stall);
            end
            @(posedge clk); #1;
            checks++;
            if (mem_req !== 1'b0) begin
                failures++;
                $display("FAIL ready_idle_req: got %b expected 0", mem_req);
            end
        end
        mem_ready = 1'b0;
        check_counters("ready_idle");
        do_op("hit_after_ready_idle", 1, 0, 16'h0040, 16'h0, 1, 3'd7, 1, 0);
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        int op;
        for (int i = 0; i < 60; i++) begin
            a = ADDR_W'(($urandom_range(0, 3) << IDX_W) | $urandom_range(0, 3));
            op = $urandom_range(0, 9);
            do_op($sformatf("rand_%0d", i),
                  (op >= 2 && op <= 5) || op == 9, op >= 6,
                  a, DATA_W'($urandom), 1'($urandom), DEST_W'($urandom), 1'($urandom),
                  $urandom_range(1, 4));
        end
    endtask

    task automatic test_saturation();
        do_op("sat_prime", 1, 0, 16'h0123, 16'h0, 1, 3'd1, 1, 2);
        in_alu_result = 16'h0123; in_mem_read = 1'b1; in_mem_write = 1'b0;
        for (int i = 0; i < CNT_MAX + 6; i++) begin
            @(posedge clk);
            exp_hit = sat_inc(exp_hit);
        end
        #1;
        checks++;
        if (hit_cnt !== {CNT_W{1'b1}}) begin
            failures++;
            $display("FAIL hit_saturate: hit=%0d expected %0d", hit_cnt, CNT_MAX);
        end
        check_counters("saturation");
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_read_miss_fill();
        test_read_hit();
        test_write_through();
        test_conflict();
        test_reset_in_flight();
        test_ready_in_idle();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
